sync_fifo_flex: RTL and testbench

Parametrised single-clock FIFO, successor to the fixed 16-bit/15-deep sync FIFO used on the analog card data paths between ADC/DAC front-end logic and the register/host interface.
- Generalised data width and depth; depth need not be a power of two.
- Adds protected writes/reads, a registered read-valid strobe, an occupancy level output, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags with clear.

---
 rtl/sync_fifo_flex.sv | 104 ++++++++++
 tb/tb_sync_fifo_flex.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, registered read port, occupancy level,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flex #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 15,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  assign full         = (level_q == DEPTH_C);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_C);
  assign almost_empty = (level_q <= AE_C);
  assign level        = level_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_acc;
    // Explicit wrap so non-power-of-two depths never index past the array.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A new error event in the same cycle as clr_err keeps the flag set.
    overflow_d  = (wr_en & full)  | (overflow_q  & ~clr_err);
    underflow_d = (rd_en & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Randomised bench for sync_fifo_flex (DEPTH=15, DATA_W=16) against a queue-based
// model, with directed scenarios pinning the model to hand-computed values.
module tb_sync_fifo_flex;

  localparam int DW    = 16;
  localparam int DEPTH = 15;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic          full, almost_full, empty, almost_empty, rd_valid, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [3:0]    level;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd_data;
  logic          exp_rd_valid;
  logic          exp_ovf, exp_udf;
  bit            model_on = 0;

  sync_fifo_flex #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .level(level), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advances on each rising edge using the inputs just sampled.
  task automatic model_update();
    int  sz;
    bit  m_full, m_empty;
    sz      = exp_q.size();
    m_full  = (sz == DEPTH);
    m_empty = (sz == 0);
    if (rst) begin
      exp_q.delete();
      exp_rd_data  = '0;
      exp_rd_valid = 1'b0;
      exp_ovf      = 1'b0;
      exp_udf      = 1'b0;
    end else begin
      exp_ovf = (wr_en && m_full) || (exp_ovf && !clr_err);
      exp_udf = (rd_en && m_empty) || (exp_udf && !clr_err);
      if (rd_en && !m_empty) begin
        exp_rd_data  = exp_q.pop_front();
        exp_rd_valid = 1'b1;
      end else begin
        exp_rd_valid = 1'b0;
      end
      if (wr_en && !m_full) exp_q.push_back(wr_data);
    end
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rs);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c; rst = rs;
    @(posedge clk);
    model_update();
    if (rs) model_on = 1;
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_on) begin
      chk("level",        32'(level),        32'(exp_q.size()));
      chk("full",         32'(full),         32'(exp_q.size() == DEPTH));
      chk("empty",        32'(empty),        32'(exp_q.size() == 0));
      chk("almost_full",  32'(almost_full),  32'(exp_q.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AE));
      chk("rd_valid",     32'(rd_valid),     32'(exp_rd_valid));
      chk("rd_data",      32'(rd_data),      32'(exp_rd_data));
      chk("overflow",     32'(overflow),     32'(exp_ovf));
      chk("underflow",    32'(underflow),    32'(exp_udf));
    end
  end

  initial begin
    int wi, ri, cyc;
    bit w, r;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a write request held high
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Fill 1..15 then drain
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      if (i == 12) chk("fill_af_12", 32'(almost_full), 0);
      if (i == 13) chk("fill_af_13", 32'(almost_full), 1);
      if (i == 14) chk("fill_full_14", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 15);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(rd_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("drain_valid_off", 32'(rd_valid), 0);
    chk("drain_hold", 32'(rd_data), 32'h000F);

    // 40 words at ~50% duty, wrapping the 15-deep pointers
    wi = 0; ri = 0; cyc = 0;
    while ((wi < 40 || ri < 40) && cyc < 600) begin
      w = (wi < 40) && ($urandom_range(1) == 1) && (exp_q.size() < DEPTH);
      r = ($urandom_range(1) == 1) && (exp_q.size() > 0);
      step(w, 16'(16'h0100 + wi), r, 1'b0, 1'b0);
      if (w) wi++;
      if (rd_valid) begin
        chk("wrap_data", 32'(rd_data), 32'(16'h0100 + ri));
        ri++;
      end
      cyc++;
    end
    chk("wrap_count", 32'(ri), 40);

    // Full with simultaneous write and read
    for (int i = 0; i < 15; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("fullsim_level", 32'(level), 14);
    chk("fullsim_ovf", 32'(overflow), 1);
    chk("fullsim_data", 32'(rd_data), 32'h0200);
    for (int i = 1; i < 15; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("fullsim_drain", 32'(rd_data), 32'(16'h0200 + i));
    end
    // Empty with simultaneous write and read
    step(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
    chk("emptysim_level", 32'(level), 1);
    chk("emptysim_udf", 32'(underflow), 1);
    chk("emptysim_valid", 32'(rd_valid), 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("clr_both_ovf", 32'(overflow), 0);
    chk("clr_both_udf", 32'(underflow), 0);

    // Overflow sticky, clear, and clear-vs-set
    for (int i = 0; i < 14; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    repeat (5) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ovf_hold", 32'(overflow), 1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 32'(overflow), 0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    chk("ovf_set_wins", 32'(overflow), 1);

    // Reset mid-operation with a read in flight
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("mid_level7", 32'(level), 7);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_valid", 32'(rd_valid), 0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("beef_valid", 32'(rd_valid), 1);
    chk("beef_data", 32'(rd_data), 32'hBEEF);

    // Random soak including clears and occasional resets
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, 16'($urandom), $urandom_range(3) != 0 && $urandom_range(1) == 1,
           $urandom_range(15) == 0, $urandom_range(99) == 0);
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
